// File: rtl/muldiv_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_unit_if : request/response bundle between core and muldiv_unit     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, flush, funct3, rs1_data, rs2_data, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, flush, funct3, rs1_data, rs2_data, rd_in,
    output busy, done, result, rd_out
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M multiply/divide, 33-cycle fixed latency     |
// | Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiplies  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input wire           clk,
  input wire           rst_n,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [5:0]        cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2:0]        op_q;
  logic              is_div_q;
  logic              neg_q;
  logic              rneg_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;
  logic              done_q;

  // Operand decode at acceptance: sign handling is folded into magnitudes
  logic [2:0]      w_op;
  logic            w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b;

  assign w_op     = bus.funct3;
  assign w_is_div = w_op[2];
  assign w_a_sgn  = w_is_div ? ~w_op[0] : (w_op[1] ^ w_op[0]);
  assign w_b_sgn  = w_is_div ? ~w_op[0] : (w_op[1:0] == 2'b01);
  assign w_a_neg  = w_a_sgn & bus.rs1_data[XLEN-1];
  assign w_b_neg  = w_b_sgn & bus.rs2_data[XLEN-1];
  assign w_mag_a  = w_a_neg ? -bus.rs1_data : bus.rs1_data;
  assign w_mag_b  = w_b_neg ? -bus.rs2_data : bus.rs2_data;
  // Divide-by-zero keeps the all-ones quotient unsigned so DIV yields -1
  assign w_neg    = (w_a_neg ^ w_b_neg) && !(w_is_div && (bus.rs2_data == {XLEN{1'b0}}));

  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_shift, w_div_trial;
  logic              w_div_ge;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_acc_next;

  assign w_mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                     + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
  assign w_mul_next  = {w_mul_sum, acc_q[XLEN-1:1]};
  assign w_div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign w_div_trial = w_div_shift - {1'b0, opnd_q};
  assign w_div_ge    = ~w_div_trial[XLEN];
  assign w_div_next  = {(w_div_ge ? w_div_trial[XLEN-1:0] : w_div_shift[XLEN-1:0]),
                        acc_q[XLEN-2:0], w_div_ge};
  assign w_acc_next  = is_div_q ? w_div_next : w_mul_next;

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_final;

  assign w_prod = neg_q  ? -w_acc_next : w_acc_next;
  assign w_quo  = neg_q  ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_rem  = rneg_q ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_final = w_quo;
    case (op_q)
      3'b000:                 w_final = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo;
      default:                w_final = w_rem;
    endcase
  end

  logic [XLEN-1:0] w_fast_res;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  logic [2*XLEN-1:0] w_fast_mag, w_fast_prod;
  assign w_fast_mag  = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
  assign w_fast_prod = w_neg ? -w_fast_mag : w_fast_mag;
  assign w_fast_res  = (w_op[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0]
                                            : w_fast_prod[2*XLEN-1:XLEN];
`else
  localparam bit FAST_MUL = 1'b0;
  assign w_fast_res = {XLEN{1'b0}};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= {(2*XLEN){1'b0}};
      opnd_q   <= {XLEN{1'b0}};
      op_q     <= 3'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      rd_q     <= 5'd0;
      result_q <= {XLEN{1'b0}};
      rd_out_q <= 5'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q     <= w_op;
            rd_q     <= bus.rd_in;
            is_div_q <= w_is_div;
            neg_q    <= w_neg;
            rneg_q   <= w_a_neg;
            cnt_q    <= 6'd0;
            opnd_q   <= w_is_div ? w_mag_b : w_mag_a;
            acc_q    <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            if (FAST_MUL && !w_is_div) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= w_fast_res;
              rd_out_q <= bus.rd_in;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= w_acc_next;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= w_final;
              rd_out_q <= rd_q;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule
`default_nettype wire
